// File: rtl/irq_pkg.sv
// Shared types for the interrupt controller: handshake FSM state encoding.
package irq_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StReq,
    StService
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder used to pick the interrupt winner.
module irq_prio_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// N-channel interrupt controller: mask, edge/level trigger, fixed priority and a
// request/ack/EOI handshake presenting one vector at a time to the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned       N_IRQ     = 8,
  parameter int unsigned       VEC_W     = $clog2(N_IRQ),
  parameter logic [N_IRQ-1:0]  EDGE_MODE = '1,
  parameter logic [N_IRQ-1:0]  MASK_RST  = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             cpu_irq,
  output logic [VEC_W-1:0] irq_vec,
  output logic [N_IRQ-1:0] mask,
  output logic [N_IRQ-1:0] pending
);

  localparam logic [N_IRQ-1:0] OneBit = {{(N_IRQ - 1){1'b0}}, 1'b1};

  irq_state_e       state;
  logic [N_IRQ-1:0] samp;
  logic [N_IRQ-1:0] prev;
  logic [VEC_W-1:0] in_service;

  logic [N_IRQ-1:0] evt;
  logic [N_IRQ-1:0] svc_level;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] pending_d;
  logic [VEC_W-1:0] win_idx;
  logic             win_valid;
  logic             ack_fire;

  always_comb begin
    evt       = (EDGE_MODE & samp & ~prev) | (~EDGE_MODE & samp);
    // A level line in service stays high until the handler quiets it; keep it
    // out of arbitration so it cannot re-request before EOI.
    svc_level = (state == StService) ? (~EDGE_MODE & (OneBit << in_service)) : '0;
    eligible  = pending & ~mask & ~svc_level;
    ack_fire  = (state == StReq) && win_valid && irq_ack;
    ack_clr   = ack_fire ? (EDGE_MODE & (OneBit << irq_vec)) : '0;
    // Edge bits: a new event in the ack cycle wins over the clear.
    pending_d = (EDGE_MODE & ((pending & ~ack_clr) | evt)) | (~EDGE_MODE & samp);
  end

  irq_prio_enc #(
    .N (N_IRQ),
    .W (VEC_W)
  ) u_prio_enc (
    .req   (eligible),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      samp    <= '0;
      prev    <= '0;
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      samp    <= irq_in;
      prev    <= samp;
      pending <= pending_d;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      cpu_irq    <= 1'b0;
      irq_vec    <= '0;
      in_service <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (win_valid) begin
            state   <= StReq;
            irq_vec <= win_idx;
            cpu_irq <= 1'b1;
          end
        end
        StReq: begin
          if (!win_valid) begin
            state   <= StIdle;
            cpu_irq <= 1'b0;
          end else if (irq_ack) begin
            // The CPU took the vector it saw, so freeze the presented one.
            state      <= StService;
            cpu_irq    <= 1'b0;
            in_service <= irq_vec;
          end else begin
            irq_vec <= win_idx;
          end
        end
        StService: begin
          if (irq_eoi) begin
            state <= StIdle;
          end
        end
        default: begin
          state   <= StIdle;
          cpu_irq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller; channel 6 is level-triggered, the rest edge.
module tb_irq_controller;

  localparam int unsigned NIrq = 8;
  localparam int unsigned VecW = 3;

  localparam int SigCpu  = 0;
  localparam int SigVec  = 1;
  localparam int SigPend = 2;
  localparam int SigMask = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [NIrq-1:0] irq_in;
  logic            mask_we;
  logic [NIrq-1:0] mask_wdata;
  logic            irq_ack;
  logic            irq_eoi;
  logic            cpu_irq;
  logic [VecW-1:0] irq_vec;
  logic [NIrq-1:0] mask;
  logic [NIrq-1:0] pending;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  irq_controller #(
    .N_IRQ     (NIrq),
    .VEC_W     (VecW),
    .EDGE_MODE (8'hBF),
    .MASK_RST  (8'hFF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .cpu_irq    (cpu_irq),
    .irq_vec    (irq_vec),
    .mask       (mask),
    .pending    (pending)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation against the DUT outputs of this cycle.
  task automatic drain();
    sb_t         e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sig)
        SigCpu:  obs = 32'(cpu_irq);
        SigVec:  obs = 32'(irq_vec);
        SigPend: obs = 32'(pending);
        default: obs = 32'(mask);
      endcase
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input logic [NIrq-1:0] lines);
    irq_in = lines;
    tick();
    irq_in = '0;
  endtask

  task automatic write_mask(input logic [NIrq-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    irq_in     = '0;
    mask_we    = 1'b0;
    mask_wdata = '0;
    irq_ack    = 1'b0;
    irq_eoi    = 1'b0;
    tick(2);
    reset = 1'b0;
    expect_val("rst_cpu", SigCpu, 0);
    expect_val("rst_vec", SigVec, 0);
    expect_val("rst_pend", SigPend, 0);
    expect_val("rst_mask", SigMask, 32'hFF);
    drain();

    write_mask('0);
    expect_val("mask_clr", SigMask, 0);
    drain();

    // Single edge pulse on channel 5.
    pulse(8'h20);
    tick();
    expect_val("p5_pend", SigPend, 32'h20);
    expect_val("p5_cpu_lat1", SigCpu, 0);
    drain();
    tick();
    expect_val("p5_cpu", SigCpu, 1);
    expect_val("p5_vec", SigVec, 5);
    drain();
    do_ack();
    expect_val("p5_ack_cpu", SigCpu, 0);
    expect_val("p5_ack_pend", SigPend, 0);
    drain();
    do_eoi();
    tick();
    expect_val("p5_idle_cpu", SigCpu, 0);
    drain();

    // Simultaneous channels 3 and 1: priority then re-request after EOI.
    pulse(8'h0A);
    tick(2);
    expect_val("p31_cpu", SigCpu, 1);
    expect_val("p31_vec1", SigVec, 1);
    drain();
    do_ack();
    expect_val("p31_ack_pend", SigPend, 32'h08);
    drain();
    do_eoi();
    expect_val("p31_gap_cpu", SigCpu, 0);
    drain();
    tick();
    expect_val("p31_rereq_cpu", SigCpu, 1);
    expect_val("p31_vec3", SigVec, 3);
    drain();
    do_ack();
    do_eoi();

    // Higher-priority arrival replaces the presented vector before ack.
    pulse(8'h10);
    tick(2);
    expect_val("pre_vec4", SigVec, 4);
    drain();
    pulse(8'h01);
    tick(2);
    expect_val("pre_cpu", SigCpu, 1);
    expect_val("pre_vec0", SigVec, 0);
    drain();
    do_ack();
    expect_val("pre_ack_vec", SigVec, 0);
    expect_val("pre_ack_pend", SigPend, 32'h10);
    drain();
    do_eoi();
    tick();
    expect_val("pre_rereq_vec", SigVec, 4);
    drain();
    do_ack();
    do_eoi();
    expect_val("pre_drained", SigPend, 0);
    drain();

    // Masked pending bit becomes eligible when unmasked.
    write_mask(8'h04);
    pulse(8'h04);
    tick(2);
    expect_val("msk_pend", SigPend, 32'h04);
    expect_val("msk_cpu", SigCpu, 0);
    drain();
    write_mask('0);
    expect_val("unmsk_cpu0", SigCpu, 0);
    drain();
    tick();
    expect_val("unmsk_cpu", SigCpu, 1);
    expect_val("unmsk_vec", SigVec, 2);
    drain();
    do_ack();
    do_eoi();

    // Level channel 6 dropping before ack withdraws the request.
    irq_in = 8'h40;
    tick(3);
    expect_val("lvl_cpu", SigCpu, 1);
    expect_val("lvl_vec", SigVec, 6);
    expect_val("lvl_pend", SigPend, 32'h40);
    drain();
    irq_in = '0;
    tick(2);
    expect_val("lvl_drop_pend", SigPend, 0);
    drain();
    tick();
    expect_val("lvl_drop_cpu", SigCpu, 0);
    drain();
    tick();
    expect_val("lvl_idle_cpu", SigCpu, 0);
    drain();

    // Reset during service, then spurious ack/eoi in idle.
    pulse(8'h80);
    tick(2);
    expect_val("svc_vec7", SigVec, 7);
    drain();
    mask_we    = 1'b1;
    mask_wdata = 8'h0F;
    do_ack();
    mask_we = 1'b0;
    irq_in  = 8'h02;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    irq_in  = '0;
    expect_val("svc_rst_cpu", SigCpu, 0);
    expect_val("svc_rst_pend", SigPend, 0);
    expect_val("svc_rst_mask", SigMask, 32'hFF);
    expect_val("svc_rst_vec", SigVec, 0);
    drain();
    irq_ack = 1'b1;
    irq_eoi = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    tick();
    expect_val("spur_cpu", SigCpu, 0);
    expect_val("spur_vec", SigVec, 0);
    expect_val("spur_pend", SigPend, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised interrupt controller that sits between peripheral interrupt sources and the `cpu` core's single `irq` input. It generalises the single-line CPU interrupt into N_IRQ channels with per-channel mask, edge or level triggering, fixed priority (channel 0 highest), and a vector/acknowledge/end-of-interrupt handshake with the CPU. One interrupt is in service at a time; there is no nesting.

## Interface

Parameters:
- N_IRQ, 8: number of interrupt channels (2..32).
- VEC_W, $clog2(N_IRQ): vector width.
- EDGE_MODE, all ones (N_IRQ bits): bit i = 1 means channel i is rising-edge triggered; 0 means level triggered (active-high).
- MASK_RST, all ones (N_IRQ bits): mask value at reset; bit = 1 means masked.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  N_IRQ  raw interrupt lines; synchronous to clock.
- mask_we  in  1  write strobe for mask register.
- mask_wdata  in  N_IRQ  new mask value.
- irq_ack  in  1  CPU accepts the presented vector.
- irq_eoi  in  1  CPU finished servicing the current interrupt.
- cpu_irq  out  1  interrupt request to CPU (registered).
- irq_vec  out  VEC_W  index of the requesting/in-service channel (registered).
- mask  out  N_IRQ  current mask register.
- pending  out  N_IRQ  current pending register.

## Operation

- Input stage: irq_in registered into `samp`; previous `samp` held in `prev`. Edge channel event = samp & ~prev; level channel event = samp.
- Pending: edge channel bit sets on event, clears on ack of that channel; if set and clear occur in the same cycle, set wins. Level channel bit follows samp every cycle, except it is ignored for arbitration while that channel is in service.
- Eligible = pending & ~mask; winner = lowest-index eligible bit.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0 -> REQ, irq_vec <= winner, cpu_irq <= 1.
  - REQ: irq_vec re-evaluated each cycle to the current winner (a higher-priority arrival replaces the vector before ack). If eligible becomes 0 (mask write or level drop) -> IDLE, cpu_irq <= 0. If irq_ack -> SERVICE, cpu_irq <= 0, irq_vec frozen, in_service channel recorded.
  - SERVICE: irq_vec holds. irq_eoi -> IDLE.
- irq_ack outside REQ and irq_eoi outside SERVICE are ignored.
- mask_we: mask <= mask_wdata next edge; masked pending bits stay pending and become eligible when unmasked.

## Timing

- Reset values: cpu_irq 0, irq_vec 0, pending 0, mask MASK_RST, samp/prev 0, state IDLE. Reset mid-handshake returns to IDLE; events in flight are discarded.
- Latency: irq_in high sampled at edge t -> pending at t+1 -> cpu_irq high after edge t+2 (2 cycles), given unmasked and state IDLE.
- Ack at edge t in REQ -> cpu_irq low after t; edge pending bit clear after t.
- EOI at edge t -> IDLE after t; a remaining eligible request raises cpu_irq after t+1 (one idle cycle minimum between services).
- Edge pulse of one cycle is captured; a held-high edge line produces exactly one event.
- Mask write takes effect for arbitration in the cycle after mask_we.

## Structure

- Package irq_pkg: state enum (IDLE, REQ, SERVICE), state width constant.
- Sub-module irq_prio_enc: combinational lowest-index priority encoder, N_IRQ in, VEC_W index + valid out; used for winner selection.

## Test plan

- Reset, mask all clear, 1-cycle pulse on irq_in[5] (edge) -> cpu_irq=1 two cycles later, irq_vec=5; ack -> cpu_irq=0, pending[5]=0; eoi -> IDLE.
- irq_in[3] and irq_in[1] pulsed same cycle -> vector 1 served first; after eoi, cpu_irq re-rises with vector 3 after one idle cycle.
- In REQ with vector 4, pulse irq_in[0] before ack -> irq_vec changes to 0; ack captures 0; pending[4] stays 1.
- Mask bit 2 set, pulse irq_in[2] -> pending[2]=1, cpu_irq stays 0; clear mask -> cpu_irq=1, irq_vec=2 two cycles later.
- Level channel 6 (EDGE_MODE[6]=0): hold irq_in[6] high -> request; drop before ack -> cpu_irq returns 0, state IDLE.
- Assert reset while in SERVICE -> next cycle cpu_irq=0, pending=0, mask=MASK_RST; spurious irq_eoi/irq_ack in IDLE cause no change.
